// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared state encoding and sizing helpers for the chunked adder scheduler
package add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  // Number of RUN cycles needed to walk an operand one chunk at a time.
  function automatic int nsteps(input int bit_num, input int chunk);
    return bit_num / chunk;
  endfunction

  // Operand width must split evenly into chunks.
  function automatic bit chunk_ok(input int bit_num, input int chunk);
    return (chunk >= 1) && (chunk <= bit_num) && ((bit_num % chunk) == 0);
  endfunction

endpackage

// File: rtl/add_chunk.sv
// rtl/add_chunk.sv - combinational W-bit adder slice with carry in and carry out
module add_chunk #(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_i,
  output logic [W-1:0] s,
  output logic         c_o
);

  // Widen by one bit so the top bit of the sum is the slice carry out.
  assign {c_o, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_i};

endmodule

// File: rtl/add_seq_arb.sv
// rtl/add_seq_arb.sv - two-requester round-robin scheduler for a chunk-serial adder
module add_seq_arb
  import add_pkg::*;
#(
  parameter int BIT_NUM = 8,
  parameter int CHUNK   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [BIT_NUM-1:0] req0_a,
  input  logic [BIT_NUM-1:0] req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [BIT_NUM-1:0] req1_a,
  input  logic [BIT_NUM-1:0] req1_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [BIT_NUM-1:0] res_o,
  output logic               res_c_o,
  output logic               res_id
);

  localparam int NSTEPS = nsteps(BIT_NUM, CHUNK);
  localparam int SW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

  generate
    if (!chunk_ok(BIT_NUM, CHUNK)) begin : g_bad_chunk
      $error("add_seq_arb: BIT_NUM must be a multiple of CHUNK");
    end
  endgenerate

  state_t             state;
  logic               last_grant;
  logic               id_q;
  logic               carry;
  logic [SW-1:0]      step;
  logic [BIT_NUM-1:0] a_q;
  logic [BIT_NUM-1:0] b_q;
  logic [BIT_NUM-1:0] acc;

  logic               grant_id;
  logic               idle_open;
  logic               xfer;
  logic               last_step;
  logic [CHUNK-1:0]   a_sl;
  logic [CHUNK-1:0]   b_sl;
  logic [CHUNK-1:0]   sum_sl;
  logic               cout;
  logic [BIT_NUM-1:0] acc_next;

  // Round-robin pick: a lone requester wins outright, a tie goes to whoever was not served last.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req1_valid;
    end
  end

  // Ready is held low during reset so nothing is accepted while the state is being forced.
  assign idle_open  = (state == S_IDLE) && !rst;
  assign req0_ready = idle_open && req0_valid && !grant_id;
  assign req1_ready = idle_open && req1_valid && grant_id;
  assign xfer       = req0_ready || req1_ready;
  assign last_step  = (step == SW'(NSTEPS - 1));

  // Select the operand chunk addressed by step and merge the slice sum back into the accumulator.
  always_comb begin
    a_sl     = '0;
    b_sl     = '0;
    acc_next = acc;
    for (int i = 0; i < NSTEPS; i++) begin
      if (step == SW'(i)) begin
        a_sl                         = a_q[i*CHUNK +: CHUNK];
        b_sl                         = b_q[i*CHUNK +: CHUNK];
        acc_next[i*CHUNK +: CHUNK]   = sum_sl;
      end
    end
  end

  add_chunk #(
    .W(CHUNK)
  ) u_chunk (
    .a   (a_sl),
    .b   (b_sl),
    .c_i (carry),
    .s   (sum_sl),
    .c_o (cout)
  );

  // Scheduler FSM: accept one add in IDLE, ripple it chunk by chunk in RUN, hold the result in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      carry      <= 1'b0;
      step       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc        <= '0;
      res_valid  <= 1'b0;
      res_o      <= '0;
      res_c_o    <= 1'b0;
      res_id     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (xfer) begin
            a_q        <= grant_id ? req1_a : req0_a;
            b_q        <= grant_id ? req1_b : req0_b;
            id_q       <= grant_id;
            last_grant <= grant_id;
            carry      <= 1'b0;
            step       <= '0;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          carry <= cout;
          if (last_step) begin
            res_valid <= 1'b1;
            res_o     <= acc_next;
            res_c_o   <= cout;
            res_id    <= id_q;
            state     <= S_DONE;
          end else begin
            step <= step + SW'(1);
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq_arb.sv
// tb/tb_add_seq_arb.sv - directed self-checking bench for add_seq_arb at CHUNK 1, 2 and 8
module tb_add_seq_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] v0, v1, rr;
  logic [2:0] rdy0, rdy1, rv, rc, rid;
  logic [7:0] a0 [3];
  logic [7:0] b0 [3];
  logic [7:0] a1 [3];
  logic [7:0] b1 [3];
  logic [7:0] ro [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: CHUNK=1, instance 1: CHUNK=2, instance 2: CHUNK=8.
  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int CH = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
      add_seq_arb #(
        .BIT_NUM(8),
        .CHUNK  (CH)
      ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (v0[g]),
        .req0_ready (rdy0[g]),
        .req0_a     (a0[g]),
        .req0_b     (b0[g]),
        .req1_valid (v1[g]),
        .req1_ready (rdy1[g]),
        .req1_a     (a1[g]),
        .req1_b     (b1[g]),
        .res_valid  (rv[g]),
        .res_ready  (rr[g]),
        .res_o      (ro[g]),
        .res_c_o    (rc[g]),
        .res_id     (rid[g])
      );
    end
  endgenerate

  function automatic int steps_of(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 4 : 1);
  endfunction

  // Present operands and hold them until the transfer edge; waited is the number of cycles stalled.
  task automatic send(input int k, input int who, input logic [7:0] a, input logic [7:0] b,
                      output int waited);
    @(negedge clk);
    if (who == 0) begin v0[k] = 1'b1; a0[k] = a; b0[k] = b; end
    else          begin v1[k] = 1'b1; a1[k] = a; b1[k] = b; end
    #1;
    waited = 0;
    while (waited < 40 && ((who == 0) ? rdy0[k] : rdy1[k]) !== 1'b1) begin
      @(negedge clk);
      #1;
      waited++;
    end
    @(posedge clk);
    #1;
    if (who == 0) v0[k] = 1'b0;
    else          v1[k] = 1'b0;
  endtask

  // Count clock edges from the transfer until res_valid rises (40 means it never did).
  task automatic wait_res(input int k, output int n);
    n = 0;
    while (n < 40 && rv[k] !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic take_res(input int k);
    @(negedge clk);
    rr[k] = 1'b1;
    @(posedge clk);
    #1;
    rr[k] = 1'b0;
  endtask

  task automatic test_reset;
    v0 = '0; v1 = '0; rr = '0;
    for (int k = 0; k < 3; k++) begin
      a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0;
    end
    #3;
    rst = 1'b1;
    v0  = 3'b111;
    v1  = 3'b111;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({rdy0[k], rdy1[k], rv[k], rc[k], rid[k], ro[k]} !== 13'd0) begin
        errors++;
        $display("FAIL reset_outputs k=%0d got %b expected 0", k,
                 {rdy0[k], rdy1[k], rv[k], rc[k], rid[k], ro[k]});
      end
    end
    #10;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (rdy0 !== 3'b111 || rdy1 !== 3'b000) begin
      errors++;
      $display("FAIL reset_first_grant got rdy0=%b rdy1=%b expected rdy0=111 rdy1=000", rdy0, rdy1);
    end
    v0 = '0;
    v1 = '0;
  endtask

  task automatic test_single(input int k);
    int w, n;
    send(k, 0, 8'h5A, 8'h33, w);
    wait_res(k, n);
    checks++;
    if (w >= 40 || n !== steps_of(k)) begin
      errors++;
      $display("FAIL single_latency k=%0d got stall=%0d lat=%0d expected stall<40 lat=%0d", k, w, n, steps_of(k));
    end
    checks++;
    if ({ro[k], rc[k], rid[k]} !== {8'h8D, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_result k=%0d got o=%h c=%b id=%b expected o=8d c=0 id=0", k, ro[k], rc[k], rid[k]);
    end
    take_res(k);
    checks++;
    if (rv[k] !== 1'b0) begin
      errors++;
      $display("FAIL single_release k=%0d got res_valid=%b expected 0", k, rv[k]);
    end
  endtask

  task automatic test_overflow(input int k);
    int w, n;
    send(k, 1, 8'hFF, 8'h01, w);
    wait_res(k, n);
    checks++;
    if (w >= 40 || n !== steps_of(k)) begin
      errors++;
      $display("FAIL overflow_latency k=%0d got stall=%0d lat=%0d expected stall<40 lat=%0d", k, w, n, steps_of(k));
    end
    checks++;
    if ({ro[k], rc[k], rid[k]} !== {8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL overflow_result k=%0d got o=%h c=%b id=%b expected o=00 c=1 id=1", k, ro[k], rc[k], rid[k]);
    end
    take_res(k);
  endtask

  task automatic test_contention;
    int n;
    logic exp_id;
    @(negedge clk);
    v0[1] = 1'b1; a0[1] = 8'h11; b0[1] = 8'h22;
    v1[1] = 1'b1; a1[1] = 8'h80; b1[1] = 8'h90;
    #1;
    for (int r = 0; r < 4; r++) begin
      exp_id = r[0];
      n = 0;
      while (n < 40 && (rdy0[1] | rdy1[1]) !== 1'b1) begin
        @(negedge clk);
        #1;
        n++;
      end
      checks++;
      if ({rdy1[1], rdy0[1]} !== (exp_id ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL contention_grant round=%0d got rdy1,rdy0=%b%b expected id %0d", r, rdy1[1], rdy0[1], exp_id);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ((rdy0[1] | rdy1[1]) !== 1'b0) begin
        errors++;
        $display("FAIL contention_run_ready round=%0d got %b%b expected 00", r, rdy1[1], rdy0[1]);
      end
      wait_res(1, n);
      checks++;
      if ({ro[1], rc[1], rid[1]} !== (exp_id ? {8'h10, 1'b1, 1'b1} : {8'h33, 1'b0, 1'b0})) begin
        errors++;
        $display("FAIL contention_result round=%0d got o=%h c=%b id=%b expected id=%0d", r, ro[1], rc[1], rid[1], exp_id);
      end
      take_res(1);
    end
    v0[1] = 1'b0;
    v1[1] = 1'b0;
  endtask

  task automatic test_backpressure;
    int w, n;
    send(1, 0, 8'h0F, 8'h01, w);
    wait_res(1, n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL bp_latency got %0d expected 4", n);
    end
    v1[1] = 1'b1; a1[1] = 8'hAA; b1[1] = 8'h55;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({rv[1], rc[1], rid[1], ro[1], rdy0[1], rdy1[1]} !== {1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d got v=%b c=%b id=%b o=%h r0=%b r1=%b expected v=1 c=0 id=0 o=10 r0=0 r1=0",
                 c, rv[1], rc[1], rid[1], ro[1], rdy0[1], rdy1[1]);
      end
    end
    v1[1] = 1'b0;
    take_res(1);
    checks++;
    if (rv[1] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got res_valid=%b expected 0", rv[1]);
    end
    v0[1] = 1'b1;
    #1;
    checks++;
    if (rdy0[1] !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle_ready got %b expected 1", rdy0[1]);
    end
    v0[1] = 1'b0;
  endtask

  task automatic test_midop_reset;
    int w, n, seen;
    send(1, 0, 8'h44, 8'h44, w);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({rv[1], ro[1], rc[1], rid[1]} !== 11'd0) begin
      errors++;
      $display("FAIL midop_clear got v=%b o=%h c=%b id=%b expected all 0", rv[1], ro[1], rc[1], rid[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (rv[1] === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midop_no_result got %0d res_valid cycles expected 0", seen);
    end
    send(1, 0, 8'h10, 8'h20, w);
    wait_res(1, n);
    checks++;
    if (n !== 4 || {ro[1], rc[1], rid[1]} !== {8'h30, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midop_next_add got lat=%0d o=%h c=%b id=%b expected lat=4 o=30 c=0 id=0", n, ro[1], rc[1], rid[1]);
    end
    take_res(1);
  endtask

  initial begin
    test_reset();
    test_single(1);
    test_overflow(1);
    test_contention();
    test_backpressure();
    test_midop_reset();
    test_single(0);
    test_overflow(0);
    test_single(2);
    test_overflow(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
